// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

  localparam int unsigned MDU_ITERS = 8;

  // Operation encoding as {op_div, op_signed}
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
module mdu_step #(
  parameter int unsigned W = 8
) (
  input  logic         i_div,
  input  logic [W-1:0] i_m,
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_q,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_q
);

  logic [W:0]   w_sum;
  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_rem} + (i_q[0] ? {1'b0, i_m} : '0);
    w_shift = {i_rem, i_q[W-1]};
    // Only used when w_shift >= i_m, so the result always fits in W bits
    w_diff  = w_shift[W-1:0] - i_m;
    o_rem   = '0;
    o_q     = '0;
    if (i_div) begin
      if (w_shift >= {1'b0, i_m}) begin
        o_rem = w_diff;
        o_q   = {i_q[W-2:0], 1'b1};
      end else begin
        o_rem = w_shift[W-1:0];
        o_q   = {i_q[W-2:0], 1'b0};
      end
    end else begin
      // {rem, q} acts as one right-shifting accumulator/multiplier register
      o_rem = w_sum[W:1];
      o_q   = {w_sum[0], i_q[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle 8-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic             i_op_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int unsigned     CntW    = $clog2(MDU_ITERS);
  localparam logic [CntW-1:0] CntInit = CntW'(MDU_ITERS - 1);

  state_e             r_state;
  state_e             w_state_d;
  logic [CntW-1:0]    r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz_pend;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic [1:0]         w_op;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_q_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  always_comb begin
    w_op     = {i_op_div, i_op_signed};
    w_is_div = (w_op == OP_DIVU) || (w_op == OP_DIV);
    w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_a_neg  = w_signed & i_a[WIDTH-1];
    w_b_neg  = w_signed & i_b[WIDTH-1];
    // -128 negates to 0x80, which is the correct unsigned magnitude
    w_a_mag  = w_a_neg ? -i_a : i_a;
    w_b_mag  = w_b_neg ? -i_b : i_b;
    w_prod   = {r_rem, r_q};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -r_q : r_q;
    w_rmd    = r_neg_r ? -r_rem : r_rem;
  end

  mdu_step #(
    .W (WIDTH)
  ) u_step (
    .i_div (r_div),
    .i_m   (r_m),
    .i_rem (r_rem),
    .i_q   (r_q),
    .o_rem (w_rem_nx),
    .o_q   (w_q_nx)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_d = StRun;
      StRun:    if (r_cnt == '0) w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_a        <= '0;
      r_m        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_div      <= w_is_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_dbz_pend <= w_is_div && (i_b == '0);
            r_a        <= i_a;
            // Divide iterates on the dividend in r_q; multiply on the multiplier
            r_m        <= w_is_div ? w_b_mag : w_a_mag;
            r_q        <= w_is_div ? w_a_mag : w_b_mag;
            r_rem      <= '0;
            r_cnt      <= CntInit;
            r_dbz      <= 1'b0;
          end
        end
        StRun: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt - 1'b1;
        end
        StFinish: begin
          r_done <= 1'b1;
          r_dbz  <= r_dbz_pend;
          if (!r_div) begin
            {r_hi, r_lo} <= w_prod_s;
          end else if (r_dbz_pend) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit against a behavioural integer model.
module tb_mul_div_unit;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_op_div;
  logic       i_op_signed;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [7:0] o_hi;
  logic [7:0] o_lo;
  logic       o_busy;
  logic       o_done;
  logic       o_div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  mul_div_unit #(
    .WIDTH (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_op_div      (i_op_div),
    .i_op_signed   (i_op_signed),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Returns {div_by_zero, hi, lo}
  function automatic logic [16:0] model(input logic div, input logic sgn,
                                        input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p, q, r;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    if (!div) begin
      p = sa * sb;
      return {1'b0, p[15:0]};
    end
    if (b == 8'h00) return {1'b1, a, 8'hFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[7:0], q[7:0]};
  endfunction

  // Called just after a falling edge; returns on the falling edge where done is seen.
  task automatic run_op(input logic div, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input int poke_at);
    logic [16:0] e;
    int lat;
    int busy_cnt;
    exp_q.push_back(model(div, sgn, a, b));
    i_start = 1'b1; i_op_div = div; i_op_signed = sgn; i_a = a; i_b = b;
    @(negedge clk);
    lat = 0;
    busy_cnt = 0;
    check("dbz_cleared_on_accept", o_div_by_zero, 0);
    while (!o_done && lat < 30) begin
      if (lat == poke_at) begin
        i_start = 1'b1; i_op_div = 1'b1; i_op_signed = 1'b0; i_a = 8'h55; i_b = 8'h00;
      end else begin
        i_start = 1'b0; i_a = 8'($urandom); i_b = 8'($urandom);
      end
      if (o_busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    check("latency", lat, 9);
    check("busy_cycles", busy_cnt, 9);
    check("busy_with_done", o_busy, 0);
    e = exp_q.pop_front();
    check("hi", o_hi, e[15:8]);
    check("lo", o_lo, e[7:0]);
    check("div_by_zero", o_div_by_zero, e[16]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hi"}, o_hi, 0);
    check({tag, "_lo"}, o_lo, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_dbz"}, o_div_by_zero, 0);
  endtask

  initial begin
    i_rst_n = 1'b1; i_start = 1'b0; i_op_div = 1'b0; i_op_signed = 1'b0;
    i_a = 8'h00; i_b = 8'h00;
    #3 i_rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    run_op(1'b0, 1'b0, 8'hC8, 8'h03, -1);
    run_op(1'b0, 1'b1, 8'hFD, 8'h05, -1);
    run_op(1'b0, 1'b1, 8'h80, 8'h80, -1);
    run_op(1'b1, 1'b0, 8'hC8, 8'h07, -1);
    run_op(1'b1, 1'b1, 8'hF9, 8'h02, -1);
    run_op(1'b1, 1'b1, 8'h80, 8'hFF, -1);
    run_op(1'b1, 1'b0, 8'h2A, 8'h00, -1);
    run_op(1'b0, 1'b0, 8'h07, 8'h09, -1);
    // A divide-by-zero start is poked mid-operation and must be ignored
    run_op(1'b0, 1'b0, 8'h11, 8'h0F, 3);
    for (int i = 0; i < 12; i++) begin
      run_op(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), -1);
    end

    // Reset in the middle of an operation
    i_start = 1'b1; i_op_div = 1'b0; i_op_signed = 1'b0; i_a = 8'hC8; i_b = 8'h03;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b0;
    #1 check_zero_outputs("midop_reset");
    @(negedge clk);
    check("held_reset_busy", o_busy, 0);
    i_rst_n = 1'b1;
    run_op(1'b1, 1'b1, 8'h64, 8'hF9, -1);
    run_op(1'b0, 1'b1, 8'h7F, 8'h81, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
